// File: rtl/memory_port_arbiter.sv
// memory_port_arbiter
// Shares one single-port memory bus between the instruction fetch port (read-only)
// and the data port (read/write, byte-masked). A registered FSM picks a winner,
// holds its latched request on mem_* until mem_ack, returns read data with a
// one-cycle ready pulse, and aborts the access with an error pulse on timeout.
// Optional feature: define ARBITER_ROUND_ROBIN_EN to alternate between ports on
// simultaneous requests; otherwise DATA_PRIORITY selects a fixed winner.
// Reset is asynchronous and active-low on the port named reset.

module memory_port_arbiter #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int DATA_PRIORITY  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    instr_enable,
    input  logic [ADDR_WIDTH-1:0]   instr_address,
    output logic [DATA_WIDTH-1:0]   instr_read_data,
    output logic                    instr_ready,
    input  logic                    data_enable,
    input  logic                    data_state,
    input  logic [ADDR_WIDTH-1:0]   data_address,
    input  logic [DATA_WIDTH/8-1:0] data_frame_mask,
    input  logic [DATA_WIDTH-1:0]   data_write_data,
    output logic [DATA_WIDTH-1:0]   data_read_data,
    output logic                    data_ready,
    output logic                    error,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH/8-1:0] mem_mask,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_ack,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    state_t                  state_q, state_next;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_next;
    logic                    last_data_q, last_data_next;

    logic                    mem_req_next, mem_we_next;
    logic [ADDR_WIDTH-1:0]   mem_addr_next;
    logic [MASK_WIDTH-1:0]   mem_mask_next;
    logic [DATA_WIDTH-1:0]   mem_wdata_next;
    logic [DATA_WIDTH-1:0]   instr_read_data_next, data_read_data_next;
    logic                    instr_ready_next, data_ready_next, error_next;

    logic                    instr_eligible, data_eligible, pick_data;

    // A port whose ready is high has just been served and must not be granted again this cycle
    always_comb begin
        instr_eligible = instr_enable & ~instr_ready;
        data_eligible  = data_enable & ~data_ready;
`ifdef ARBITER_ROUND_ROBIN_EN
        pick_data = data_eligible & (~instr_eligible | ~last_data_q);
`else
        pick_data = data_eligible & (~instr_eligible | (DATA_PRIORITY != 0));
`endif
    end

    // Next-state and next-output logic: arbitrate in IDLE, wait for ack or timeout while granted
    always_comb begin
        state_next           = state_q;
        cnt_next             = cnt_q;
        last_data_next       = last_data_q;
        mem_req_next         = mem_req;
        mem_we_next          = mem_we;
        mem_addr_next        = mem_addr;
        mem_mask_next        = mem_mask;
        mem_wdata_next       = mem_wdata;
        instr_read_data_next = instr_read_data;
        data_read_data_next  = data_read_data;
        instr_ready_next     = 1'b0;
        data_ready_next      = 1'b0;
        error_next           = 1'b0;

        case (state_q)
            IDLE: begin
                if (instr_eligible | data_eligible) begin
                    cnt_next     = '0;
                    mem_req_next = 1'b1;
                    if (pick_data) begin
                        state_next     = GRANT_D;
                        last_data_next = 1'b1;
                        mem_we_next    = data_state;
                        mem_addr_next  = data_address;
                        mem_mask_next  = data_state ? data_frame_mask : {MASK_WIDTH{1'b1}};
                        mem_wdata_next = data_write_data;
                    end else begin
                        state_next     = GRANT_I;
                        last_data_next = 1'b0;
                        mem_we_next    = 1'b0;
                        mem_addr_next  = instr_address;
                        mem_mask_next  = {MASK_WIDTH{1'b1}};
                        mem_wdata_next = '0;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                if (mem_ack || (cnt_q == CNT_LAST)) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    mem_req_next = 1'b0;
                    error_next   = ~mem_ack;
                    if (state_q == GRANT_I) begin
                        instr_ready_next     = 1'b1;
                        instr_read_data_next = mem_ack ? mem_rdata : '0;
                    end else begin
                        data_ready_next     = 1'b1;
                        data_read_data_next = mem_ack ? mem_rdata : '0;
                    end
                end else begin
                    cnt_next = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
            end
        endcase
    end

    // State, counter and all registered outputs; reset drops mem_req immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            last_data_q     <= 1'b0;
            mem_req         <= 1'b0;
            mem_we          <= 1'b0;
            mem_addr        <= '0;
            mem_mask        <= '0;
            mem_wdata       <= '0;
            instr_read_data <= '0;
            data_read_data  <= '0;
            instr_ready     <= 1'b0;
            data_ready      <= 1'b0;
            error           <= 1'b0;
        end else begin
            state_q         <= state_next;
            cnt_q           <= cnt_next;
            last_data_q     <= last_data_next;
            mem_req         <= mem_req_next;
            mem_we          <= mem_we_next;
            mem_addr        <= mem_addr_next;
            mem_mask        <= mem_mask_next;
            mem_wdata       <= mem_wdata_next;
            instr_read_data <= instr_read_data_next;
            data_read_data  <= data_read_data_next;
            instr_ready     <= instr_ready_next;
            data_ready      <= data_ready_next;
            error           <= error_next;
        end
    end

endmodule
